io_interrupt_bridge: RTL
========================

# io_interrupt_bridge

External-device side of the processor's I/O and interrupt interface. It buffers words from a device in a small FIFO and presents the FIFO head on the core's `input_port`. It raises `interrupt_signal` toward the core whenever buffered data is pending, and pops a word only when the core acknowledges it. It also captures changes on the core's `out_port` and offers them to the device through a valid/ready handshake.

## Interface
- `DEPTH`, 4, input FIFO depth in words; power of 2, minimum 2.
- `INT_PULSE`, 1, cycles `interrupt_signal` is held high per request; 1..15.
- `INT_GAP`, 2, minimum idle cycles after an acknowledge before the next request; 1..15.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dev_data`  in  16  device word to enqueue.
- `dev_valid`  in  1  device offers `dev_data`.
- `dev_ready`  out  1  FIFO can accept a word; registered.
- `input_port`  out  16  FIFO head word; 16'h0000 when the FIFO is empty.
- `interrupt_signal`  out  1  interrupt request to the core; registered.
- `in_ack`  in  1  core has consumed `input_port`; pops the head word.
- `out_port`  in  16  core output port value.
- `out_data`  out  16  captured `out_port` value.
- `out_valid`  out  1  `out_data` is pending for the device.
- `out_ready`  in  1  device accepts `out_data`.
- `out_overrun`  out  1  sticky flag; a pending capture was overwritten.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **FIFO:** read/write pointers of $clog2(DEPTH)+1 bits; wrap modulo 2·DEPTH.
  - Full when the low bits are equal and the MSBs differ.
  - Empty when the pointers are equal.
- **Push:** occurs when `dev_valid && dev_ready`.
  - `dev_ready` = registered !full, computed from the next-state occupancy.
- **Pop:** occurs when `in_ack` is high and the FIFO is not empty.
  - `in_ack` while empty is ignored and changes no state.
- **Simultaneous push and pop:** the occupancy is unchanged and both pointers advance.
  - When full, the push is already blocked because `dev_ready`=0.
- **Interrupt FSM:** IDLE, ASSERT, WAIT_ACK, GAP.
  - IDLE: if the FIFO is not empty, go to ASSERT, set `interrupt_signal`=1 and load the counter with INT_PULSE.
  - ASSERT: decrement the counter; at 1, clear `interrupt_signal` and go to WAIT_ACK.
  - WAIT_ACK: stay until a valid pop, then go to GAP with the counter loaded to INT_GAP.
  - GAP: decrement the counter; at 1, go to IDLE. IDLE re-requests if data remains.
  - `in_ack` during ASSERT pops the word normally. The FSM still completes the pulse, then skips WAIT_ACK and goes straight to GAP.
- **Out capture:** `out_prev` register.
  - When `out_port != out_prev`: `out_data`←`out_port`, `out_prev`←`out_port`, `out_valid`←1.
  - Transfer occurs on `out_valid && out_ready`; `out_valid` drops the next cycle.
  - A change in the same cycle as a transfer loads the new value and keeps `out_valid`=1. This is not an overrun.
  - A change while `out_valid=1` with no transfer overwrites `out_data` and sets `out_overrun`. Only `rst` clears `out_overrun`.

## Timing
- **Reset values, all outputs:**
  - 0 while `rst` is high: `dev_ready`, `input_port`, `interrupt_signal`, `out_data`, `out_valid`, `out_overrun`, `level`.
  - `dev_ready`=1 from the first cycle after `rst` is deasserted.
  - FSM returns to IDLE; pointers and `out_prev` are cleared to 0.
- **Reset mid-operation:** buffered words are discarded, and any pulse in progress drops on the next edge.
- **Push to `input_port`:** a word pushed at edge N appears on `input_port` after edge N, with `level` updated.
- **Interrupt latency:** a push at edge N into an empty FIFO with the FSM in IDLE gives `interrupt_signal` high after edge N+1, for INT_PULSE cycles.
- **Pop:** `in_ack` sampled at edge M advances `input_port` to the next word after edge M.
- **Back-to-back requests:** the minimum spacing between request rising edges is INT_PULSE + INT_GAP + 1 cycles.
- **Out capture latency:** a change on `out_port` sampled at edge K gives `out_valid`=1 after edge K.

## Configuration
- Macro `IO_OUT_CAPTURE_EN`.
- **Defined:** out-capture logic as specified above.
- **Undefined:** `out_prev` and the capture logic are removed.
  - `out_valid`, `out_overrun` and `out_data` are tied to 0.
  - `out_port` and `out_ready` are ignored.
  - FIFO and interrupt behaviour are unchanged.

## Test plan
- **Reset, then single word:** push 16'hA5A5 at cycle 1.
  - `input_port`=16'hA5A5 and `level`=1 after cycle 1.
  - `interrupt_signal` high for exactly 1 cycle after cycle 2.
  - `in_ack` then gives `level`=0 and `input_port`=0.
- **Fill:** push 16'h0001..16'h0005 back-to-back, no acks.
  - `dev_ready` falls after the 4th push; the 5th word is not accepted and `level`=4.
- **Simultaneous push/pop when full:** `in_ack` together with `dev_valid`.
  - One word is popped; `dev_ready` rises on the next cycle, and the next push is accepted.
- **Repeated requests:** queue 3 words with INT_PULSE=2 and INT_GAP=3, acking each request in WAIT_ACK.
  - Exactly 3 pulses, each 2 cycles wide, at least 6 cycles apart.
- **Reset mid-operation:** assert `rst` during ASSERT with `level`=3.
  - All outputs are 0 on the next cycle; no further interrupt occurs until a new push.
- **Out capture (`IO_OUT_CAPTURE_EN` defined):**
  - `out_port` changes 0→16'h0010 with `out_ready`=0: `out_valid`=1 and `out_data`=16'h0010.
  - A further change to 16'h0020 gives `out_data`=16'h0020 and `out_overrun`=1.
  - Then `out_ready`=1: `out_valid`=0 on the next cycle.

Source files
------------

// File: rtl/io_interrupt_bridge.sv
// rtl/io_interrupt_bridge.sv - device-to-core FIFO with interrupt requests and out_port capture
// Optional out-capture path enabled by macro IO_OUT_CAPTURE_EN.
module io_interrupt_bridge #(
  parameter int DEPTH     = 4,
  parameter int INT_PULSE = 1,
  parameter int INT_GAP   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              dev_data,
  input  logic                     dev_valid,
  output logic                     dev_ready,
  output logic [15:0]              input_port,
  output logic                     interrupt_signal,
  input  logic                     in_ack,
  input  logic [15:0]              out_port,
  output logic [15:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_overrun,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ASSERT   = 2'd1;
  localparam logic [1:0] S_WAIT_ACK = 2'd2;
  localparam logic [1:0] S_GAP      = 2'd3;

  logic [15:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_next, rd_next;
  logic        empty, push, pop, full_next;
  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        acked;

  assign empty      = (wr_ptr == rd_ptr);
  assign push       = dev_valid && dev_ready;
  assign pop        = in_ack && !empty;
  assign wr_next    = wr_ptr + {{AW{1'b0}}, push};
  assign rd_next    = rd_ptr + {{AW{1'b0}}, pop};
  assign full_next  = (wr_next[AW-1:0] == rd_next[AW-1:0]) && (wr_next[AW] != rd_next[AW]);
  assign level      = wr_ptr - rd_ptr;
  assign input_port = empty ? 16'h0000 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= dev_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      dev_ready <= 1'b0;
    end else begin
      wr_ptr    <= wr_next;
      rd_ptr    <= rd_next;
      dev_ready <= !full_next;
    end
  end

  // An ack taken during the pulse is remembered so WAIT_ACK can be skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      cnt              <= 4'd0;
      acked            <= 1'b0;
      interrupt_signal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            state            <= S_ASSERT;
            interrupt_signal <= 1'b1;
            cnt              <= 4'(INT_PULSE);
            acked            <= 1'b0;
          end
        end
        S_ASSERT: begin
          if (pop) acked <= 1'b1;
          if (cnt == 4'd1) begin
            interrupt_signal <= 1'b0;
            if (acked || pop) begin
              state <= S_GAP;
              cnt   <= 4'(INT_GAP);
            end else begin
              state <= S_WAIT_ACK;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_WAIT_ACK: begin
          if (pop) begin
            state <= S_GAP;
            cnt   <= 4'(INT_GAP);
          end
        end
        default: begin
          if (cnt == 4'd1) state <= S_IDLE;
          else             cnt   <= cnt - 4'd1;
        end
      endcase
    end
  end

`ifdef IO_OUT_CAPTURE_EN
  logic [15:0] out_prev;

  // A change coinciding with a transfer reloads without flagging an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_prev    <= 16'h0000;
      out_data    <= 16'h0000;
      out_valid   <= 1'b0;
      out_overrun <= 1'b0;
    end else if (out_port != out_prev) begin
      out_prev  <= out_port;
      out_data  <= out_port;
      out_valid <= 1'b1;
      if (out_valid && !out_ready) out_overrun <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
`else
  logic unused_out;
  assign unused_out  = ^{out_port, out_ready};
  assign out_data    = 16'h0000;
  assign out_valid   = 1'b0;
  assign out_overrun = 1'b0;
`endif

endmodule
